// File: rtl/decoded_instr_queue_if.sv
// Decoded-instruction type shared by decode and execute, plus the handshake
// bundle that connects decode, the instruction queue and execute.
package instruction;
   typedef enum logic [3:0] {
      OP_NOP    = 4'd0,
      OP_ADD    = 4'd1,
      OP_SUB    = 4'd2,
      OP_AND    = 4'd3,
      OP_OR     = 4'd4,
      OP_LOAD   = 4'd5,
      OP_STORE  = 4'd6,
      OP_BRANCH = 4'd7,
      OP_JUMP   = 4'd8
   } op_e;

   typedef struct packed {
      op_e         op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } t;

   localparam t NOP = '{op: OP_NOP, default: '0};
endpackage

interface decoded_instr_queue_if #(
   parameter int DEPTH = 4
);
   localparam int PTR_W = $clog2(DEPTH);

   logic            flush;
   logic            in_valid;
   logic            in_ready;
   instruction::t   in_instr;
   logic [31:0]     in_pc;
   logic            out_valid;
   logic            out_ready;
   instruction::t   out_instr;
   logic [31:0]     out_pc;
   logic [PTR_W:0]  count;

   // master is the pipeline around the queue (decode + execute), slave is the queue.
   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, count
   );

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_instr, out_pc, count
   );
endinterface

// File: rtl/decoded_instr_queue.sv
// Decode-to-execute FIFO of {decoded instruction, PC}; no bypass, single-cycle
// flush, and NOP/zero presented at the head whenever the queue is empty.
module decoded_instr_queue #(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   decoded_instr_queue_if.slave q_if
);

   typedef struct packed {
      instruction::t instr;
      logic [31:0]   pc;
   } entry_t;

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q,  count_d;

   logic full, empty, push, pop;

   // in_ready comes from registered count only, so a full queue refuses even a same-cycle pop.
   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = q_if.in_valid && !full  && !q_if.flush;
   assign pop   = !empty && q_if.out_ready && !q_if.flush;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (q_if.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; count gates every read, so stale data is never visible.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{instr: q_if.in_instr, pc: q_if.in_pc};
   end

   assign q_if.in_ready  = !full;
   assign q_if.out_valid = !empty;
   assign q_if.out_instr = empty ? instruction::NOP : mem_q[rd_ptr_q].instr;
   assign q_if.out_pc    = empty ? 32'b0            : mem_q[rd_ptr_q].pc;
   assign q_if.count     = count_q;

endmodule

// File: tb/tb_decoded_instr_queue.sv
// Self-checking bench for decoded_instr_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_decoded_instr_queue;

   localparam int DEPTH = 4;

   typedef struct {
      instruction::t ins;
      logic [31:0]   pc;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   decoded_instr_queue_if #(.DEPTH(DEPTH)) dq ();

   decoded_instr_queue #(.DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .q_if (dq.slave)
   );

   ent_t mq[$];
   int   vectors     = 0;
   int   miscompares = 0;
   bit   last_accept;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic instruction::t rand_instr();
      instruction::t r;
      r.op  = instruction::op_e'($urandom_range(1, 8));
      r.rd  = 5'($urandom);
      r.rs1 = 5'($urandom);
      r.rs2 = 5'($urandom);
      r.imm = $urandom;
      return r;
   endfunction

   // Reference: reset/flush empty the queue; otherwise pop the head if there is one
   // and execute is ready, and append the offer if the queue was not full before the edge.
   task automatic model_edge();
      int sz = mq.size();
      last_accept = 1'b0;
      if (rst || dq.flush) begin
         mq.delete();
      end else begin
         if (sz > 0 && dq.out_ready) void'(mq.pop_front());
         if (dq.in_valid && sz < DEPTH) begin
            mq.push_back('{ins: dq.in_instr, pc: dq.in_pc});
            last_accept = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      bit            exp_valid = (mq.size() != 0);
      instruction::t exp_ins   = exp_valid ? mq[0].ins : instruction::NOP;
      logic [31:0]   exp_pc    = exp_valid ? mq[0].pc  : 32'b0;
      check("count",     64'(dq.count),     64'(mq.size()));
      check("out_valid", 64'(dq.out_valid), 64'(exp_valid));
      check("in_ready",  64'(dq.in_ready),  64'(mq.size() != DEPTH));
      check("out_instr", 64'(dq.out_instr), 64'(exp_ins));
      check("out_pc",    64'(dq.out_pc),    64'(exp_pc));
      check("count_le_depth", 64'(dq.count <= DEPTH), 64'(1));
      check("nop_when_empty", 64'(dq.out_valid || (dq.out_instr == instruction::NOP)), 64'(1));
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic set_in(input bit v, input logic [31:0] pc);
      dq.in_valid = v;
      dq.in_pc    = pc;
      dq.in_instr = v ? rand_instr() : instruction::NOP;
   endtask

   initial begin
      rst          = 1'b1;
      dq.flush     = 1'b0;
      dq.out_ready = 1'b0;
      set_in(1'b0, 32'h0);

      // Reset then idle.
      tick();
      rst = 1'b0;
      tick();
      check("rst_valid", 64'(dq.out_valid), 64'(0));
      check("rst_ready", 64'(dq.in_ready),  64'(1));
      check("rst_instr", 64'(dq.out_instr), 64'(instruction::NOP));

      // Fill to DEPTH, then a held fifth offer must be refused.
      for (int k = 0; k < 4; k++) begin
         set_in(1'b1, 32'h100 + 32'(4 * k));
         tick();
      end
      check("full_count", 64'(dq.count), 64'(4));
      set_in(1'b1, 32'h110);
      dq.out_ready = 1'b0;
      tick();
      tick();
      check("full_hold_pc", 64'(dq.out_pc), 64'h100);
      check("full_ready",   64'(dq.in_ready), 64'(0));

      // Drain in order.
      set_in(1'b0, 32'h0);
      dq.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("drain_pc", 64'(dq.out_pc), 64'(32'h100 + 32'(4 * k)));
         tick();
      end
      check("drained_valid", 64'(dq.out_valid), 64'(0));

      // Steady streaming: one-deep occupancy, pointers wrap several times.
      for (int k = 0; k < 10; k++) begin
         set_in(1'b1, 32'h200 + 32'(4 * k));
         tick();
         check("stream_cnt", 64'(dq.count), 64'(1));
         check("stream_pc",  64'(dq.out_pc), 64'(32'h200 + 32'(4 * k)));
      end
      set_in(1'b0, 32'h0);
      tick();

      // Flush beats a same-cycle push and pop.
      dq.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_in(1'b1, 32'h280 + 32'(4 * k));
         tick();
      end
      set_in(1'b1, 32'h2F0);
      dq.out_ready = 1'b1;
      dq.flush     = 1'b1;
      tick();
      dq.flush = 1'b0;
      set_in(1'b0, 32'h0);
      check("flush_cnt",   64'(dq.count),     64'(0));
      check("flush_instr", 64'(dq.out_instr), 64'(instruction::NOP));
      tick();
      check("flush_stay_empty", 64'(dq.out_valid), 64'(0));

      // Reset mid-operation, then a lone push.
      dq.out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         set_in(1'b1, 32'h2A0 + 32'(4 * k));
         tick();
      end
      set_in(1'b0, 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("midrst_valid", 64'(dq.out_valid), 64'(0));
      set_in(1'b1, 32'h300);
      tick();
      set_in(1'b0, 32'h0);
      check("after_rst_pc",  64'(dq.out_pc), 64'h300);
      check("after_rst_cnt", 64'(dq.count),  64'(1));

      // Randomized traffic; a refused offer is held stable until taken or flushed.
      last_accept = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if (!(dq.in_valid && !last_accept && !dq.flush && !rst))
            set_in(($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC);
         dq.out_ready = ($urandom_range(0, 2) != 0);
         dq.flush     = ($urandom_range(0, 19) == 0);
         rst          = ($urandom_range(0, 99) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
